// File: rtl/pio_pkg.sv
// pio_pkg -- shared types for the PIO configuration sequencer.
//   pio_action_t : PIO host-port action codes driven on 'action'
//   seq_state_t  : sequencer FSM states
//   seq_cfg_t    : configuration captured on start
//   clamp_len    : limits the program length to the program store depth
package pio_pkg;

    typedef enum logic [3:0] {
        ACT_NONE  = 4'd0,
        ACT_INSTR = 4'd1,
        ACT_PEND  = 4'd2,
        ACT_PUSH  = 4'd4,
        ACT_GRPS  = 4'd5,
        ACT_EN    = 4'd6,
        ACT_DIV   = 4'd7,
        ACT_SIDES = 4'd8,
        ACT_IMM   = 4'd9
    } pio_action_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_PEND,
        ST_DIV,
        ST_GRPS,
        ST_SIDES,
        ST_EN,
        ST_STREAM
    } seq_state_t;

    typedef struct packed {
        logic [5:0]  n;        // number of program words to load
        logic [4:0]  pend;
        logic [23:0] div;
        logic [31:0] grps;
        logic [4:0]  sideset;
        logic [1:0]  mach;
        logic [3:0]  en_mask;
    } seq_cfg_t;

    function automatic logic [5:0] clamp_len(input logic [5:0] plen,
                                             input logic [5:0] max_len);
        return (plen > max_len) ? max_len : plen;
    endfunction

endpackage

// File: rtl/pio_cfg_seq.sv
// pio_cfg_seq -- loads a program and machine configuration into a PIO block
// through its host port, then streams TX words into the selected machine.
//
// Optional feature: define PIO_CFG_SEQ_IMM_EN to add an immediate-instruction
// port (imm_valid/imm_data/imm_ready) that preempts TX pushes while streaming.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   start, abort      start a configuration run / return to idle
//   plen..en_mask     configuration, captured when start is accepted
//   prog_addr/_data   external program ROM, one-cycle read latency
//   tx_valid/_data/_ready  upstream TX word stream
//   pio_full          per-machine TX FIFO full flags from the PIO
//   action/index/mindex/din  registered PIO host-port command
//   busy, done        sequencer active / pulse on entering STREAM
//
// Timing: whatever a state decides in a cycle appears on the registered
// host-port outputs in the following cycle.
module pio_cfg_seq
    import pio_pkg::*;
#(
    parameter int PROG_DEPTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  plen,
    input  logic [4:0]  pend,
    input  logic [23:0] div,
    input  logic [31:0] pin_grps,
    input  logic [4:0]  sideset,
    input  logic [1:0]  mach,
    input  logic [3:0]  en_mask,
    output logic [4:0]  prog_addr,
    input  logic [15:0] prog_data,
    input  logic        tx_valid,
    input  logic [31:0] tx_data,
    output logic        tx_ready,
    input  logic [3:0]  pio_full,
`ifdef PIO_CFG_SEQ_IMM_EN
    input  logic        imm_valid,
    input  logic [15:0] imm_data,
    output logic        imm_ready,
`endif
    output logic [3:0]  action,
    output logic [4:0]  index,
    output logic [1:0]  mindex,
    output logic [31:0] din,
    output logic        busy,
    output logic        done
);

    localparam logic [5:0] PROG_MAX = 6'(PROG_DEPTH);

    seq_state_t  state_reg,  state_next;
    logic [5:0]  k_reg,      k_next;
    seq_cfg_t    cfg_reg,    cfg_next;
    pio_action_t action_reg, action_next;
    logic [4:0]  index_reg,  index_next;
    logic [1:0]  mindex_reg, mindex_next;
    logic [31:0] din_reg,    din_next;
    logic        done_reg,   done_next;

    // LOAD cycle k presents address k; the word read here arrives next cycle.
    assign prog_addr = (state_reg == ST_LOAD) ? k_reg[4:0] : 5'd0;
    assign busy      = (state_reg != ST_IDLE);

    // A cycle showing PUSH is the one in which the PIO takes the word; its
    // full flag is only trustworthy again one cycle later.
    assign tx_ready = (state_reg == ST_STREAM) && !pio_full[cfg_reg.mach]
                      && (action_reg != ACT_PUSH)
`ifdef PIO_CFG_SEQ_IMM_EN
                      && !imm_valid
`endif
                      ;

`ifdef PIO_CFG_SEQ_IMM_EN
    assign imm_ready = (state_reg == ST_STREAM);
`endif

    assign action = action_reg;
    assign index  = index_reg;
    assign mindex = mindex_reg;
    assign din    = din_reg;
    assign done   = done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            k_reg      <= '0;
            cfg_reg    <= '0;
            action_reg <= ACT_NONE;
            index_reg  <= '0;
            mindex_reg <= '0;
            din_reg    <= '0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            cfg_reg    <= cfg_next;
            action_reg <= action_next;
            index_reg  <= index_next;
            mindex_reg <= mindex_next;
            din_reg    <= din_next;
            done_reg   <= done_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        k_next      = k_reg;
        cfg_next    = cfg_reg;
        action_next = ACT_NONE;
        index_next  = '0;
        mindex_next = '0;
        din_next    = '0;
        done_next   = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    cfg_next = '{n:       clamp_len(plen, PROG_MAX),
                                 pend:    pend,
                                 div:     div,
                                 grps:    pin_grps,
                                 sideset: sideset,
                                 mach:    mach,
                                 en_mask: en_mask};
                    k_next     = '0;
                    state_next = (plen == 6'd0) ? ST_PEND : ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Cycle 0 only primes the ROM; from cycle 1 on, prog_data
                // holds the word addressed in the previous cycle.
                if (k_reg != 6'd0) begin
                    action_next = ACT_INSTR;
                    index_next  = 5'(k_reg - 6'd1);
                    din_next    = {16'h0, prog_data};
                end
                if (k_reg == cfg_reg.n) state_next = ST_PEND;
                else                    k_next     = k_reg + 6'd1;
            end
            ST_PEND: begin
                action_next = ACT_PEND;
                din_next    = {27'h0, cfg_reg.pend};
                state_next  = ST_DIV;
            end
            ST_DIV: begin
                action_next = ACT_DIV;
                din_next    = {8'h0, cfg_reg.div};
                state_next  = ST_GRPS;
            end
            ST_GRPS: begin
                action_next = ACT_GRPS;
                din_next    = cfg_reg.grps;
                state_next  = ST_SIDES;
            end
            ST_SIDES: begin
                action_next = ACT_SIDES;
                din_next    = {27'h0, cfg_reg.sideset};
                state_next  = ST_EN;
            end
            ST_EN: begin
                action_next = ACT_EN;
                din_next    = {28'h0, cfg_reg.en_mask};
                state_next  = ST_STREAM;
            end
            ST_STREAM: begin
                // First STREAM cycle is the one where EN is on the outputs.
                done_next = (action_reg == ACT_EN);
`ifdef PIO_CFG_SEQ_IMM_EN
                if (imm_valid) begin
                    action_next = ACT_IMM;
                    din_next    = {16'h0, imm_data};
                end else
`endif
                if (tx_valid && tx_ready) begin
                    action_next = ACT_PUSH;
                    din_next    = tx_data;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (action_next != ACT_NONE) mindex_next = cfg_reg.mach;

        // Abort wins over everything issued this cycle, including a handshake.
        if (abort) begin
            state_next  = ST_IDLE;
            action_next = ACT_NONE;
            index_next  = '0;
            mindex_next = '0;
            din_next    = '0;
            done_next   = 1'b0;
        end
    end

endmodule

// File: tb/tb_pio_cfg_seq.sv
// tb_pio_cfg_seq -- directed self-checking bench for pio_cfg_seq.
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_pio_cfg_seq;

    localparam logic [3:0] A_NONE  = 4'd0;
    localparam logic [3:0] A_INSTR = 4'd1;
    localparam logic [3:0] A_PEND  = 4'd2;
    localparam logic [3:0] A_PUSH  = 4'd4;
    localparam logic [3:0] A_GRPS  = 4'd5;
    localparam logic [3:0] A_EN    = 4'd6;
    localparam logic [3:0] A_DIV   = 4'd7;
    localparam logic [3:0] A_SIDES = 4'd8;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [5:0]  plen;
    logic [4:0]  pend;
    logic [23:0] div;
    logic [31:0] pin_grps;
    logic [4:0]  sideset;
    logic [1:0]  mach;
    logic [3:0]  en_mask;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic [3:0]  pio_full;
`ifdef PIO_CFG_SEQ_IMM_EN
    logic        imm_valid;
    logic [15:0] imm_data;
    logic        imm_ready;
`endif
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic        busy, done;

    logic [15:0] rom [0:31];
    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    // Program ROM model: synchronous read, one cycle of latency.
    always @(posedge clk) prog_data <= rom[prog_addr];

    pio_cfg_seq #(.PROG_DEPTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .plen(plen), .pend(pend), .div(div), .pin_grps(pin_grps),
        .sideset(sideset), .mach(mach), .en_mask(en_mask),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .pio_full(pio_full),
`ifdef PIO_CFG_SEQ_IMM_EN
        .imm_valid(imm_valid), .imm_data(imm_data), .imm_ready(imm_ready),
`endif
        .action(action), .index(index), .mindex(mindex), .din(din),
        .busy(busy), .done(done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %-16s = %h", tag, got);
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Call when the next edge is expected to put PEND on the outputs.
    task automatic expect_tail(input logic [4:0] p, input logic [23:0] d,
                               input logic [31:0] g, input logic [4:0] s,
                               input logic [3:0] e, input logic [1:0] m);
        tick(); check("pend action", action, A_PEND);
        check("pend din", din, {27'h0, p});
        check("pend mindex", mindex, m);
        tick(); check("div action", action, A_DIV);
        check("div din", din, {8'h0, d});
        tick(); check("grps action", action, A_GRPS);
        check("grps din", din, g);
        tick(); check("sides action", action, A_SIDES);
        check("sides din", din, {27'h0, s});
        tick(); check("en action", action, A_EN);
        check("en din", din, {28'h0, e});
        check("done with en", done, 1'b0);
        tick(); check("done pulse", done, 1'b1);
        check("action after en", action, A_NONE);
        tick(); check("done cleared", done, 1'b0);
        check("stream busy", busy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 16'h1000 + 16'(i) * 16'h0101;
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        plen = 6'd0; pend = '0; div = '0; pin_grps = '0; sideset = '0;
        mach = '0; en_mask = '0; tx_valid = 1'b0; tx_data = '0; pio_full = '0;
`ifdef PIO_CFG_SEQ_IMM_EN
        imm_valid = 1'b0; imm_data = '0;
`endif
        tick(); tick();
        check("rst action", action, A_NONE);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst tx_ready", tx_ready, 1'b0);
        check("rst prog_addr", prog_addr, 5'd0);
        check("rst din", din, 32'h0);
        reset = 1'b0;
        tick();

        // Full run: 7 program words then the configuration tail.
        plen = 6'd7; pend = 5'd6; div = 24'h000280; pin_grps = 32'h20000000;
        sideset = 5'd1; mach = 2'd0; en_mask = 4'd1; start = 1'b1;
        tick(); start = 1'b0;
        check("load busy", busy, 1'b1);
        check("load addr0", prog_addr, 5'd0);
        tick(); check("load k0 none", action, A_NONE);
        check("load addr1", prog_addr, 5'd1);
        for (int i = 0; i < 7; i++) begin
            tick();
            check("instr action", action, A_INSTR);
            check("instr index", index, 5'(i));
            check("instr din", din, {16'h0, rom[i]});
        end
        expect_tail(5'd6, 24'h000280, 32'h20000000, 5'd1, 4'd1, 2'd0);

        // Two back-to-back words: pushes separated by a NONE cycle.
        tx_data = 32'd2; tx_valid = 1'b1; #1;
        check("ready idle", tx_ready, 1'b1);
        tick(); check("push2 action", action, A_PUSH);
        check("push2 din", din, 32'd2);
        tx_data = 32'd4;
        check("ready after push", tx_ready, 1'b0);
        tick(); check("push gap", action, A_NONE);
        check("ready again", tx_ready, 1'b1);
        tick(); check("push4 action", action, A_PUSH);
        check("push4 din", din, 32'd4);
        tx_valid = 1'b0;

        // FIFO full holds the word back; exactly one push once it drains.
        pio_full = 4'b0001; tx_data = 32'h55; tx_valid = 1'b1; #1;
        check("full ready", tx_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(); check("full no push", action, A_NONE);
        end
        pio_full = 4'b0000; #1;
        check("drain ready", tx_ready, 1'b1);
        tick(); check("pending push", action, A_PUSH);
        check("pending din", din, 32'h55);
        tx_valid = 1'b0;
        tick(); check("single push a", action, A_NONE);
        tick(); check("single push b", action, A_NONE);

`ifdef PIO_CFG_SEQ_IMM_EN
        // Immediate instruction preempts a pending TX word.
        imm_valid = 1'b1; imm_data = 16'h8080; tx_valid = 1'b1; tx_data = 32'h77; #1;
        check("imm ready", imm_ready, 1'b1);
        check("imm stalls tx", tx_ready, 1'b0);
        tick(); check("imm action", action, 4'd9);
        check("imm din", din, 32'h00008080);
        imm_valid = 1'b0;
        tick(); check("push after imm", action, A_PUSH);
        check("push after imm d", din, 32'h77);
        tx_valid = 1'b0;
        tick();
`endif

        // Abort beats a same-cycle handshake; the word is dropped.
        tx_valid = 1'b1; tx_data = 32'h99; abort = 1'b1; #1;
        check("abort hs ready", tx_ready, 1'b1);
        tick(); check("abort drops", action, A_NONE);
        check("abort idle", busy, 1'b0);
        check("abort tx_ready", tx_ready, 1'b0);
        abort = 1'b0; tx_valid = 1'b0;
        tick(); check("abort quiet", action, A_NONE);

        // plen=0: straight into the configuration tail on machine 2.
        plen = 6'd0; pend = 5'h13; div = 24'h123456; pin_grps = 32'hdeadbeef;
        sideset = 5'h1f; mach = 2'd2; en_mask = 4'ha; start = 1'b1;
        tick(); start = 1'b0;
        check("plen0 busy", busy, 1'b1);
        check("plen0 no instr", action, A_NONE);
        expect_tail(5'h13, 24'h123456, 32'hdeadbeef, 5'h1f, 4'ha, 2'd2);
        pio_full = 4'b0100; tx_valid = 1'b1; #1;
        check("mach2 full", tx_ready, 1'b0);
        pio_full = 4'b0001; #1;
        check("other mach full", tx_ready, 1'b1);
        tx_valid = 1'b0; pio_full = 4'b0000; abort = 1'b1;
        tick(); abort = 1'b0;

        // Abort during LOAD k=3, then a clean restart from index 0.
        plen = 6'd7; mach = 2'd0; start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick(); tick();
        check("abort k3 addr", prog_addr, 5'd3);
        check("k3 index", index, 5'd1);
        abort = 1'b1;
        tick(); abort = 1'b0;
        check("load abort act", action, A_NONE);
        check("load abort busy", busy, 1'b0);
        start = 1'b1;
        tick(); start = 1'b0;
        tick(); tick();
        check("restart action", action, A_INSTR);
        check("restart index", index, 5'd0);
        check("restart din", din, {16'h0, rom[0]});

        // Reset during LOAD, and reset over start.
        reset = 1'b1;
        tick();
        check("rst load action", action, A_NONE);
        check("rst load busy", busy, 1'b0);
        check("rst load addr", prog_addr, 5'd0);
        start = 1'b1;
        tick(); check("rst over start", busy, 1'b0);
        reset = 1'b0; start = 1'b0;
        tick(); check("after rst quiet", action, A_NONE);

        // plen beyond the store depth is capped at 32 words.
        plen = 6'd40; pend = 5'd2; div = 24'h1; pin_grps = 32'h1;
        sideset = 5'd0; en_mask = 4'hf; start = 1'b1;
        tick(); start = 1'b0;
        tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            check("cap index", {action, 3'b000, index}, {A_INSTR, 3'b000, 5'(i)});
            check("cap din", din, {16'h0, rom[i]});
        end
        expect_tail(5'd2, 24'h1, 32'h1, 5'd0, 4'hf, 2'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
